// File: rtl/nmr_alu_pkg.sv
// Shared definitions for the N-modular-redundant ALU: alucont encodings,
// a population-count helper and the mismatch-counter width function.
package nmr_alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Number of set bits; callers zero-extend narrower vectors to 32 bits.
  function automatic int popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) c = c + 1;
    end
    return c;
  endfunction

  // Bits needed to hold a counter that saturates at thresh.
  function automatic int cnt_width(input int thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/nmr_alu_core.sv
// One combinational ALU replica. bit2 of alucont inverts b with carry-in 1
// for SUM/SLT; the logic ops always see the unmodified b, so codes 100/101
// behave as AND/OR.
module nmr_alu_core
  import nmr_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucont,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] b_mod;
  logic [WIDTH-1:0] sum;

  // Adder path shared by ADD, SUB and SLT, then result select.
  always_comb begin
    b_mod = alucont[2] ? ~b : b;
    sum   = a + b_mod + {{(WIDTH-1){1'b0}}, alucont[2]};
    case (alucont)
      ALU_AND, 3'b100: y = a & b;
      ALU_OR,  3'b101: y = a | b;
      ALU_ADD, ALU_SUB: y = sum;
      default:          y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
    endcase
  end

endmodule

// File: rtl/nmr_alu_voter.sv
// Registered N-modular-redundant ALU: N replicas, bitwise majority vote over
// the replicas still in service, per-replica saturating mismatch counters
// with retirement, and one valid/ready output stage.
// Optional feature macro: NMR_ALU_FAULT_INJECT_EN adds inj_sel/inj_bits,
// which XOR selected replica outputs before voting.
module nmr_alu_voter
  import nmr_alu_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int N            = 5,
  parameter int FAULT_THRESH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucont,
  input  logic             clear_faults,
`ifdef NMR_ALU_FAULT_INJECT_EN
  input  logic [N-1:0]     inj_sel,
  input  logic [WIDTH-1:0] inj_bits,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [N-1:0]     fault_mask,
  output logic             degraded,
  output logic             uncorrectable
);

  localparam int            CW     = cnt_width(FAULT_THRESH);
  localparam logic [CW-1:0] THRESH = CW'(FAULT_THRESH);

  logic [WIDTH-1:0] core_y [N];
  logic [WIDTH-1:0] rep_y  [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_rep
    nmr_alu_core #(.WIDTH(WIDTH)) u_core (
      .a       (a),
      .b       (b),
      .alucont (alucont),
      .y       (core_y[gi])
    );
`ifdef NMR_ALU_FAULT_INJECT_EN
    assign rep_y[gi] = inj_sel[gi] ? (core_y[gi] ^ inj_bits) : core_y[gi];
`else
    assign rep_y[gi] = core_y[gi];
`endif
  end

  logic [N-1:0]     enabled;
  int               k_en;
  logic [WIDTH-1:0] voted;
  logic             tie;
  logic [N-1:0]     mismatch;
  logic             accept;

  assign enabled  = ~fault_mask;
  assign k_en     = popcount(32'(enabled));
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Bitwise majority over enabled replicas; a tie resolves to 0 and is flagged.
  always_comb begin
    int ones;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    voted    = '0;
    tie      = 1'b0;
    mismatch = '0;
    ones     = 0;
    for (int j = 0; j < WIDTH; j++) begin
      ones = 0;
      for (int i = 0; i < N; i++) begin
        if (enabled[i] && rep_y[i][j]) ones = ones + 1;
      end
      voted[j] = (2 * ones > k_en);
      if (2 * ones == k_en) tie = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      mismatch[i] = enabled[i] && (rep_y[i] != voted);
    end
  end

  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N-1:0]  retire_cand;
  logic [N-1:0]  retire;
  logic [N-1:0]  mask_d;
  logic [N-1:0]  en_d;

  // Next counter values and retirement set; never retire the last replica.
  always_comb begin
    retire_cand = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept && enabled[i]) begin
        if (mismatch[i]) cnt_d[i] = (cnt_q[i] == THRESH) ? cnt_q[i] : cnt_q[i] + CW'(1);
        else             cnt_d[i] = '0;
      end
      retire_cand[i] = accept && enabled[i] && (cnt_d[i] == THRESH);
    end
    retire = retire_cand;
    if (retire_cand != '0 && retire_cand == enabled) begin
      // Keep the lowest-index candidate in service.
      retire = retire_cand & ~(retire_cand & (~retire_cand + N'(1)));
    end
    mask_d = clear_faults ? '0 : (fault_mask | retire);
    en_d   = ~mask_d;
  end

  // Fault bookkeeping: counters, sticky fault mask and the degraded flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_mask <= '0;
      degraded   <= 1'b0;
      // NOTE: the counter array is reset explicitly; stale counts would retire healthy replicas.
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      fault_mask <= mask_d;
      degraded   <= (popcount(32'(en_d)) < 3);
      for (int i = 0; i < N; i++) cnt_q[i] <= clear_faults ? '0 : cnt_d[i];
    end
  end

  // Output stage: capture on accept, hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      result        <= '0;
      zero          <= 1'b1;
      uncorrectable <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      result        <= voted;
      zero          <= (voted == '0);
      uncorrectable <= tie;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule
